// File: rtl/fifo_wr_arbiter_if.sv
// Handshake bundle between the two producers, the consumer, the shared FIFO
// and the write arbiter in front of it.
interface fifo_wr_arbiter_if #(
    parameter int DATA_SIZE = 32,
    parameter int CNT_SIZE  = 5
);
    logic                 req0_valid;
    logic [DATA_SIZE-1:0] req0_data;
    logic                 req0_ready;
    logic                 req1_valid;
    logic [DATA_SIZE-1:0] req1_data;
    logic                 req1_ready;
    logic                 pop_req;
    logic                 pop_ack;
    logic                 pop_valid;
    logic [DATA_SIZE-1:0] fifo_data_in;
    logic                 fifo_w_e;
    logic                 fifo_r_e;
    logic [CNT_SIZE-1:0]  level;
    logic                 full;
    logic                 empty;

    // producer/consumer/FIFO side
    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, pop_req,
        input  req0_ready, req1_ready, pop_ack, pop_valid,
               fifo_data_in, fifo_w_e, fifo_r_e, level, full, empty
    );

    // arbiter side
    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, pop_req,
        output req0_ready, req1_ready, pop_ack, pop_valid,
               fifo_data_in, fifo_w_e, fifo_r_e, level, full, empty
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter for a FIFO with no status flags. Keeps its own
// occupancy count (including words still in the one-cycle write pipeline)
// and derives full/empty back-pressure from it.
module fifo_wr_arbiter #(
    parameter int DATA_SIZE = 32,
    parameter int DEPTH     = 16,
    parameter int CNT_SIZE  = 5
) (
    input logic              clk,
    input logic              nRST,
    fifo_wr_arbiter_if.slave bus
);
    logic                 prio;
    logic                 pref_valid;
    logic                 other_valid;
    logic                 win_valid;
    logic                 win_sel;
    logic [DATA_SIZE-1:0] win_data;
    logic                 accept;
    logic                 pop_ack;
    logic [CNT_SIZE-1:0]  level;
    logic [CNT_SIZE-1:0]  level_nxt;
    logic                 full;
    logic                 empty;
    logic                 w_e;
    logic                 r_e;
    logic                 pop_valid;
    logic [DATA_SIZE-1:0] data_in;

    // winner selection: preferred producer if valid, otherwise the other one
    always_comb begin
        pref_valid  = prio ? bus.req1_valid : bus.req0_valid;
        other_valid = prio ? bus.req0_valid : bus.req1_valid;
        win_valid   = pref_valid | other_valid;
        win_sel     = pref_valid ? prio : ~prio;
        win_data    = win_sel ? bus.req1_data : bus.req0_data;
        accept      = win_valid & ~full;
        pop_ack     = bus.pop_req & ~empty;
    end

    // next occupancy; simultaneous accept and pop cancel out
    always_comb begin
        level_nxt = level;
        case ({accept, pop_ack})
            2'b10:   level_nxt = level + 1'b1;
            2'b01:   level_nxt = level - 1'b1;
            default: level_nxt = level;
        endcase
    end

    // priority, FIFO strobes, read-valid pipeline and occupancy flags
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            prio      <= 1'b0;
            w_e       <= 1'b0;
            data_in   <= '0;
            r_e       <= 1'b0;
            pop_valid <= 1'b0;
            level     <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
        end else begin
            if (accept) begin
                prio    <= ~win_sel;
                data_in <= win_data;
            end
            w_e       <= accept;
            r_e       <= pop_ack;
            pop_valid <= r_e;
            level     <= level_nxt;
            full      <= (level_nxt == CNT_SIZE'(DEPTH));
            empty     <= (level_nxt == '0);
        end
    end

    assign bus.req0_ready   = win_valid & ~win_sel & ~full;
    assign bus.req1_ready   = win_valid &  win_sel & ~full;
    assign bus.pop_ack      = pop_ack;
    assign bus.pop_valid    = pop_valid;
    assign bus.fifo_data_in = data_in;
    assign bus.fifo_w_e     = w_e;
    assign bus.fifo_r_e     = r_e;
    assign bus.level        = level;
    assign bus.full         = full;
    assign bus.empty        = empty;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: a simple FIFO sits behind the arbiter, a
// queue-based reference model is compared on every falling edge, and a few
// directed scenarios pin literal values.
module tb_fifo_wr_arbiter;
    localparam int DATA_SIZE = 32;
    localparam int DEPTH     = 16;
    localparam int CNT_SIZE  = 5;

    logic clk  = 1'b0;
    logic nRST = 1'b0;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.DATA_SIZE(DATA_SIZE), .CNT_SIZE(CNT_SIZE)) bus ();

    fifo_wr_arbiter #(.DATA_SIZE(DATA_SIZE), .DEPTH(DEPTH), .CNT_SIZE(CNT_SIZE)) dut (
        .clk  (clk),
        .nRST (nRST),
        .bus  (bus)
    );

    // physical FIFO: write on w_e, registered read data on r_e
    logic [DATA_SIZE-1:0] fmem [0:DEPTH-1];
    logic [3:0]           fwp, frp;
    logic [DATA_SIZE-1:0] fdout;
    always @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            fwp   <= '0;
            frp   <= '0;
            fdout <= '0;
        end else begin
            if (bus.fifo_w_e) begin
                fmem[fwp] <= bus.fifo_data_in;
                fwp       <= fwp + 4'd1;
            end
            if (bus.fifo_r_e) begin
                fdout <= fmem[frp];
                frp   <= frp + 4'd1;
            end
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference model: stored words as a queue, level is its size
    logic [DATA_SIZE-1:0] q[$];
    logic                 m_prio = 1'b0;
    logic                 m_we = 1'b0, m_re = 1'b0, m_pv = 1'b0;
    logic [DATA_SIZE-1:0] m_din = '0, m_rdata = '0, m_pdata = '0;

    always @(negedge clk) begin : model
        logic [1:0]           vv;
        logic                 has_win, win, e_full, acc, ack;
        logic [DATA_SIZE-1:0] wdata;
        if (!nRST) begin
            q.delete();
            m_prio  = 1'b0;
            m_we    = 1'b0;
            m_din   = '0;
            m_re    = 1'b0;
            m_pv    = 1'b0;
            m_rdata = '0;
            m_pdata = '0;
        end
        vv      = {bus.req1_valid, bus.req0_valid};
        has_win = vv[m_prio] | vv[~m_prio];
        win     = vv[m_prio] ? m_prio : ~m_prio;
        e_full  = (q.size() == DEPTH);
        acc     = has_win & ~e_full;
        ack     = bus.pop_req & (q.size() != 0);

        chk("req0_ready", {31'd0, bus.req0_ready}, {31'd0, acc & (win == 1'b0)});
        chk("req1_ready", {31'd0, bus.req1_ready}, {31'd0, acc & (win == 1'b1)});
        chk("pop_ack",    {31'd0, bus.pop_ack},    {31'd0, ack});
        chk("level",      {27'd0, bus.level},      32'(q.size()));
        chk("full",       {31'd0, bus.full},       {31'd0, e_full});
        chk("empty",      {31'd0, bus.empty},      {31'd0, q.size() == 0});
        chk("fifo_w_e",   {31'd0, bus.fifo_w_e},   {31'd0, m_we});
        chk("fifo_data_in", bus.fifo_data_in,      m_din);
        chk("fifo_r_e",   {31'd0, bus.fifo_r_e},   {31'd0, m_re});
        chk("pop_valid",  {31'd0, bus.pop_valid},  {31'd0, m_pv});
        if (m_pv) chk("pop_data", fdout, m_pdata);

        if (nRST) begin
            m_pv    = m_re;
            m_pdata = m_rdata;
            if (ack) m_rdata = q.pop_front();
            m_re = ack;
            m_we = acc;
            if (acc) begin
                wdata  = win ? bus.req1_data : bus.req0_data;
                m_din  = wdata;
                q.push_back(wdata);
                m_prio = ~win;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.pop_req    = 1'b0;
    endtask

    initial begin
        idle_inputs();
        bus.req0_data = '0;
        bus.req1_data = '0;
        nRST = 1'b0;
        step();
        step();
        @(negedge clk);
        chk("rst_empty", {31'd0, bus.empty}, 32'd1);
        chk("rst_level", {27'd0, bus.level}, 32'd0);
        step();
        nRST = 1'b1;

        // alternation: both valid, grants 0,1,0,1...
        for (int k = 0; k < DEPTH; k++) begin
            bus.req0_valid = 1'b1;
            bus.req1_valid = 1'b1;
            bus.req0_data  = 32'hA000_0000 + 32'(k / 2);
            bus.req1_data  = 32'hB000_0000 + 32'(k / 2);
            @(negedge clk);
            chk("alt_ready0", {31'd0, bus.req0_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("alt_ready1", {31'd0, bus.req1_ready}, (k % 2 == 1) ? 32'd1 : 32'd0);
            step();
        end
        @(negedge clk);
        chk("alt_full",   {31'd0, bus.full},       32'd1);
        chk("alt_level",  {27'd0, bus.level},      32'd16);
        chk("alt_rdy0",   {31'd0, bus.req0_ready}, 32'd0);
        chk("alt_rdy1",   {31'd0, bus.req1_ready}, 32'd0);
        step();

        // full with pop
        bus.req1_valid = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req0_data  = 32'hC000_0001;
        bus.pop_req    = 1'b1;
        @(negedge clk);
        chk("fullpop_ack",  {31'd0, bus.pop_ack},    32'd1);
        chk("fullpop_rdy0", {31'd0, bus.req0_ready}, 32'd0);
        step();
        bus.pop_req = 1'b0;
        @(negedge clk);
        chk("fullpop_lvl15", {27'd0, bus.level},      32'd15);
        chk("fullpop_rdy0b", {31'd0, bus.req0_ready}, 32'd1);
        step();
        bus.req0_valid = 1'b0;
        @(negedge clk);
        chk("fullpop_lvl16", {27'd0, bus.level}, 32'd16);
        step();

        // drain, data order checked by the model
        bus.pop_req = 1'b1;
        repeat (DEPTH + 2) step();
        idle_inputs();
        repeat (3) step();

        // single producer, req1 only for 5 cycles
        for (int k = 0; k < 5; k++) begin
            bus.req1_valid = 1'b1;
            bus.req1_data  = $urandom;
            @(negedge clk);
            chk("single_rdy1", {31'd0, bus.req1_ready}, 32'd1);
            if (k == 0) chk("single_we0", {31'd0, bus.fifo_w_e}, 32'd0);
            if (k == 1) chk("single_we1", {31'd0, bus.fifo_w_e}, 32'd1);
            step();
        end
        bus.req1_valid = 1'b0;
        @(negedge clk);
        chk("single_level", {27'd0, bus.level}, 32'd5);
        step();

        // bring level to 3, then accept and pop together
        bus.pop_req = 1'b1;
        step();
        step();
        bus.req0_valid = 1'b1;
        bus.req0_data  = 32'hD00D_0003;
        @(negedge clk);
        chk("simul_ack",  {31'd0, bus.pop_ack},    32'd1);
        chk("simul_rdy0", {31'd0, bus.req0_ready}, 32'd1);
        step();
        idle_inputs();
        @(negedge clk);
        chk("simul_level", {27'd0, bus.level}, 32'd3);
        step();
        bus.pop_req = 1'b1;
        repeat (4) step();
        idle_inputs();
        repeat (3) step();

        // write-to-read ordering
        bus.req0_valid = 1'b1;
        bus.req0_data  = 32'h1234_5678;
        @(negedge clk);
        chk("order_rdy0", {31'd0, bus.req0_ready}, 32'd1);
        step();
        bus.req0_valid = 1'b0;
        bus.pop_req    = 1'b1;
        @(negedge clk);
        chk("order_ack", {31'd0, bus.pop_ack}, 32'd1);
        step();
        @(negedge clk);
        chk("order_re", {31'd0, bus.fifo_r_e}, 32'd1);
        step();
        @(negedge clk);
        chk("order_pv",    {31'd0, bus.pop_valid}, 32'd1);
        chk("order_data",  fdout,                  32'h1234_5678);
        chk("order_empty", {31'd0, bus.empty},     32'd1);
        step();
        idle_inputs();

        // randomized traffic with a mid-stream reset
        begin
            int p0, p1, pp;
            p0 = 50; p1 = 50; pp = 50;
            for (int c = 0; c < 2500; c++) begin
                if (c % 250 == 0) begin
                    p0 = $urandom_range(10, 95);
                    p1 = $urandom_range(10, 95);
                    pp = $urandom_range(10, 95);
                end
                if (c == 1200) begin
                    idle_inputs();
                    nRST = 1'b0;
                    step();
                    step();
                    nRST = 1'b1;
                    bus.req0_valid = 1'b1;
                    bus.req1_valid = 1'b1;
                    bus.req0_data  = $urandom;
                    bus.req1_data  = $urandom;
                    @(negedge clk);
                    chk("post_rst_rdy0", {31'd0, bus.req0_ready}, 32'd1);
                    chk("post_rst_rdy1", {31'd0, bus.req1_ready}, 32'd0);
                    step();
                end
                bus.req0_valid = ($urandom_range(0, 99) < p0);
                bus.req1_valid = ($urandom_range(0, 99) < p1);
                bus.pop_req    = ($urandom_range(0, 99) < pp);
                bus.req0_data  = $urandom;
                bus.req1_data  = $urandom;
                step();
            end
        end
        idle_inputs();
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Controller that shares one `fifo` instance between two producers and one consumer. It arbitrates producer writes round-robin and drives the FIFO's `w_e`/`data_in`/`r_e`. The FIFO exposes no full or empty flags, so the block keeps its own occupancy count and applies back-pressure from it. It sits directly in front of the FIFO on the same clock, and the FIFO's `data_out` goes straight to the consumer.

## Interface
- `DATA_SIZE`, 32, width of data words
- `DEPTH`, 16, usable FIFO capacity in words; must not exceed the FIFO's physical depth
- `CNT_SIZE`, 5, occupancy counter width; must satisfy 2**CNT_SIZE > DEPTH
- `clk`  in  1  single clock, all logic on rising edge
- `nRST`  in  1  reset, asynchronous, active-low
- `req0_valid`  in  1  producer 0 has a word
- `req0_data`  in  DATA_SIZE  producer 0 word
- `req0_ready`  out  1  producer 0 word accepted this cycle (combinational)
- `req1_valid`  in  1  producer 1 has a word
- `req1_data`  in  DATA_SIZE  producer 1 word
- `req1_ready`  out  1  producer 1 word accepted this cycle (combinational)
- `pop_req`  in  1  consumer requests one word
- `pop_ack`  out  1  pop accepted this cycle (combinational)
- `pop_valid`  out  1  FIFO `data_out` holds the popped word this cycle
- `fifo_data_in`  out  DATA_SIZE  to FIFO `data_in` (registered)
- `fifo_w_e`  out  1  to FIFO `w_e` (registered)
- `fifo_r_e`  out  1  to FIFO `r_e` (registered)
- `level`  out  CNT_SIZE  accepted words not yet popped (registered)
- `full`  out  1  level == DEPTH (registered)
- `empty`  out  1  level == 0 (registered)

## Operation
**Arbitration**
- Priority register `prio` is 1 bit and resets to 0, meaning producer 0 is preferred.
- The winner is the preferred producer if it is valid. Otherwise it is the other producer if that one is valid.
- `reqN_ready` = winner==N && !full. At most one ready is high per cycle.
- On an accept (valid&&ready), `prio` is set to the other producer. With no accept, `prio` holds.

**Write path**
- An accept in cycle T produces, at edge end-of-T, `fifo_w_e`<=1 and `fifo_data_in`<=winner data.
- With no accept, `fifo_w_e`<=0 and `fifo_data_in` holds.
- The FIFO writes the word at edge end-of-T+1.

**Pop path**
- `pop_ack` = pop_req && !empty.
- An ack in T produces `fifo_r_e`=1 in T+1 and `pop_valid`=1 in T+2, when the FIFO read data is valid.

**Occupancy**
- `level` changes by +1 on an accept only, by -1 on a pop only, and by 0 when both or neither occur.
- `full`/`empty` are recomputed from next-level.
- An accept is never granted when full, so overflow cannot occur. A pop is never acked when empty, so underflow cannot occur.
- `level` is allowed to count words still in the write pipeline. A pop acked the cycle after the first accept reads at end-of-T+2, after the write at end-of-T+1, so ordering is preserved.

**Reset**
- nRST low asynchronously clears all registers: `fifo_w_e`, `fifo_r_e`, `pop_valid`, `level`, `full`, `fifo_data_in` to 0; `empty` to 1; `prio` to 0.
- Reset mid-operation discards all in-flight words. The FIFO pointers must be reset by the same nRST.

## Timing
- Accept to FIFO write strobe: 1 cycle. Accept to stored: 2 edges.
- Pop ack to `fifo_r_e`: 1 cycle. Pop ack to `pop_valid` with data on FIFO `data_out`: 2 cycles.
- Sustained throughput is 1 write and 1 pop per cycle.
- When full, a simultaneous pop does not free space in the same cycle: ready is low, and ready rises the next cycle.
- With both producers valid continuously and not full, grants alternate 0,1,0,1.
- Ready paths are combinational from `reqN_valid`, `prio` and `full` only, with no dependency on `pop_req`.

## Test plan
- **Reset values:** assert nRST low mid-stream -> all outputs 0 except `empty`=1. Release -> first grant goes to req0 when both are valid.
- **Alternation:** both producers valid continuously, DEPTH=16, no pops -> grants alternate 0,1,... The 16 words A0,B0,A1,B1... are accepted. `full`=1 after the 16th accept and both readies are 0.
- **Single producer:** req1 only, valid for 5 cycles -> 5 consecutive accepts, `level`=5. `fifo_w_e` is high for 5 cycles, starting one cycle after the first accept.
- **Full with pop:** `level`=16, `pop_req` and `req0_valid` both high -> `pop_ack`=1, `req0_ready`=0. `level`=15 next cycle, then req0 is accepted and `level` returns to 16.
- **Simultaneous accept and pop:** `level`=3 with accept and pop in the same cycle -> `level` stays 3. `fifo_r_e` one cycle later and `pop_valid` two cycles later, carrying the oldest word.
- **Write-to-read ordering:** empty, accept word 0x12345678, `pop_req` held high -> `pop_ack` in the next cycle. `pop_valid` with `data_out`=0x12345678 arrives 2 cycles after the ack, and `empty` returns to 1.
